ahb_lite_sram_slave: RTL and testbench

AHB-Lite "Junior" bus slave that sits directly downstream of the bus master. It consumes the master's HADDR/HWRITE/HWDATA and returns HRDATA/HREADY. It is backed by a word-addressed register-array memory, inserts a configurable number of wait states, and returns a two-cycle error response for illegal addresses.

---
 rtl/ahb_lite_sram_slave_if.sv | 20 ++
 rtl/ahb_lite_sram_slave.sv | 117 +++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the SRAM slave.
interface ahb_lite_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a word-addressed register array. It adds
// WAIT_STATES wait cycles to every legal data phase and answers illegal
// addresses with a two-cycle ERROR response.
module ahb_lite_sram_slave #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_lite_sram_slave_if.slave s_bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  logic [31:0]   r_mem [DEPTH];
  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_next;
  logic          r_write;
  logic          w_write_next;
  logic [32:0]   w_diff;
  logic          w_legal;
  logic          w_sample;
  logic          w_mem_we;

  // A 33-bit difference exposes addresses below the base through the borrow
  // bit; the remaining fields give alignment, word index and range overflow.
  assign w_diff  = {1'b0, s_bus.HADDR} - {1'b0, BASE_ADDR};
  assign w_legal = !w_diff[32] && (w_diff[31:AW+2] == '0) && (w_diff[1:0] == 2'b00);

  // State register: FSM state, wait counter and captured address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_write <= w_write_next;
    end
  end

  // Next state: count wait cycles, then sample a new address phase whenever
  // the slave is ready (IDLE, completing DATA, ERR2).
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_write_next = r_write;
    w_sample     = 1'b0;
    case (r_state)
      ST_IDLE: w_sample = 1'b1;
      ST_DATA: begin
        if (r_cnt != WS) w_cnt_next = r_cnt + 4'd1;
        else             w_sample   = 1'b1;
      end
      ST_ERR1: w_state_next = ST_ERR2;
      ST_ERR2: w_sample = 1'b1;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_sample) begin
      if (!s_bus.HSEL) begin
        w_state_next = ST_IDLE;
      end else if (w_legal) begin
        w_state_next = ST_DATA;
        w_cnt_next   = '0;
        w_idx_next   = w_diff[AW+1:2];
        w_write_next = s_bus.HWRITE;
      end else begin
        w_state_next = ST_ERR1;
      end
    end
  end

  // Outputs: read data comes straight from the array for the whole read data
  // phase; the write strobe fires only on the completing cycle.
  always_comb begin
    s_bus.HREADY = 1'b1;
    s_bus.HRESP  = 1'b0;
    s_bus.HRDATA = '0;
    w_mem_we     = 1'b0;
    case (r_state)
      ST_DATA: begin
        s_bus.HREADY = (r_cnt == WS);
        if (!r_write) s_bus.HRDATA = r_mem[r_idx];
        w_mem_we = r_write && (r_cnt == WS);
      end
      ST_ERR1: begin
        s_bus.HREADY = 1'b0;
        s_bus.HRESP  = 1'b1;
      end
      ST_ERR2: s_bus.HRESP = 1'b1;
      default: ;
    endcase
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge HCLK) begin
    if (w_mem_we) r_mem[r_idx] <= s_bus.HWDATA;
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench: four slave instances with different geometry and wait
// states, driven by a pipelined AHB master task and checked against a
// transaction-level memory model.
module tb_ahb_lite_sram_slave;

  typedef struct {
    bit          sel;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    bit          known;
  } txn_t;

  typedef struct {
    int          inst;
    bit          sel;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       t_sel;
  logic [3:0][31:0] t_addr;
  logic [3:0]       t_wr;
  logic [3:0][31:0] t_wdata;
  logic [3:0]       o_rdy;
  logic [3:0]       o_resp;
  logic [3:0][31:0] o_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  txn_t        q[$];
  logic [31:0] mm [4][256];
  bit          mv [4][256];
  vec_t        tv [NV];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int          WS = (gi == 1) ? 3 : (gi == 2) ? 2 : (gi == 3) ? 1 : 0;
    localparam int          DP = (gi == 0) ? 256 : (gi == 3) ? 16 : 64;
    localparam logic [31:0] BA = (gi == 3) ? 32'h0000_0400 : 32'h0000_0000;

    ahb_lite_sram_slave_if u_if ();
    assign u_if.HSEL   = t_sel[gi];
    assign u_if.HADDR  = t_addr[gi];
    assign u_if.HWRITE = t_wr[gi];
    assign u_if.HWDATA = t_wdata[gi];
    assign o_rdy[gi]   = u_if.HREADY;
    assign o_resp[gi]  = u_if.HRESP;
    assign o_rdata[gi] = u_if.HRDATA;

    ahb_lite_sram_slave #(
      .DEPTH(DP), .BASE_ADDR(BA), .WAIT_STATES(WS)
    ) u_dut (
      .HCLK(clk), .HRESETn(rst_n), .s_bus(u_if)
    );
  end

  function automatic logic [31:0] base_of(input int k);
    return (k == 3) ? 32'h0000_0400 : 32'h0000_0000;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 256 : (k == 3) ? 16 : 64;
  endfunction

  function automatic int ws_of(input int k);
    return (k == 1) ? 3 : (k == 2) ? 2 : (k == 3) ? 1 : 0;
  endfunction

  // Legal = word aligned and inside [base, base + 4*depth), in 64-bit math.
  function automatic bit legal(input int k, input logic [31:0] a);
    longint lo, hi, x;
    lo = {32'b0, base_of(k)};
    x  = {32'b0, a};
    hi = lo + 4 * depth_of(k);
    return (a % 4 == 0) && (x >= lo) && (x < hi);
  endfunction

  function automatic int word_of(input int k, input logic [31:0] a);
    return int'((a - base_of(k)) / 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pipelined master: runs queue q on instance k. Called and returns at a
  // negedge. Address-phase signals and HWDATA are scrambled in wait cycles.
  task automatic run_q(input int k);
    int n, cur, nxt, waits, budget, exp_w;
    logic rdy, rsp;
    logic [31:0] rd, exp_rd;
    bit is_rd, skip_rd;
    n = q.size(); cur = -1; nxt = 0; waits = 0; budget = 0;
    while (cur < n) begin
      rdy = o_rdy[k]; rsp = o_resp[k]; rd = o_rdata[k];
      if (cur >= 0) begin
        is_rd   = q[cur].sel && !q[cur].wr && !q[cur].exp_err;
        skip_rd = is_rd && !q[cur].known;
        exp_rd  = is_rd ? q[cur].exp_rdata : 32'h0;
        chk($sformatf("hresp i%0d #%0d", k, cur), {31'b0, rsp}, {31'b0, q[cur].sel & q[cur].exp_err});
        if (!skip_rd) chk($sformatf("hrdata i%0d #%0d", k, cur), rd, exp_rd);
        if (rdy) begin
          exp_w = !q[cur].sel ? 0 : q[cur].exp_err ? 1 : ws_of(k);
          chk($sformatf("waits i%0d #%0d", k, cur), 32'(waits), 32'(exp_w));
          if (q[cur].sel)
            $display("txn i%0d #%0d %s addr=%h wdata=%h resp=%0d rdata=%h waits=%0d",
                     k, cur, q[cur].wr ? "W" : "R", q[cur].addr, q[cur].wdata, rsp, rd, waits);
          else
            $display("txn i%0d #%0d idle", k, cur);
        end else begin
          waits++;
        end
      end
      if (rdy) begin
        if (nxt < n) begin
          t_sel[k] = q[nxt].sel; t_addr[k] = q[nxt].addr; t_wr[k] = q[nxt].wr;
        end else begin
          t_sel[k] = 1'b0; t_addr[k] = $urandom; t_wr[k] = 1'($urandom);
        end
      end else begin
        t_sel[k] = 1'($urandom); t_addr[k] = $urandom; t_wr[k] = 1'($urandom);
      end
      t_wdata[k] = (cur >= 0 && rdy) ? q[cur].wdata : $urandom;
      @(posedge clk);
      if (rdy) begin
        cur = nxt; nxt++; waits = 0;
      end
      @(negedge clk);
      budget++;
      if (budget > 20 * n + 20) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout i%0d: stuck at txn %0d of %0d", k, cur, n);
        break;
      end
    end
    t_sel[k] = 1'b0;
    q.delete();
  endtask

  task automatic model_write(input int k, input txn_t t);
    int wi;
    if (t.sel && t.wr && legal(k, t.addr)) begin
      wi = word_of(k, t.addr);
      mm[k][wi] = t.wdata;
      mv[k][wi] = 1'b1;
    end
  endtask

  task automatic gen_random(input int k, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      txn_t t;
      logic [31:0] a;
      int r, w, wi;
      t.sel   = ($urandom_range(0, 99) < 88);
      t.wr    = 1'($urandom);
      t.wdata = $urandom;
      w = ($urandom_range(0, 9) == 0) ? depth_of(k) - 1 : $urandom_range(0, 7);
      a = base_of(k) + 32'(w) * 32'd4;
      r = $urandom_range(0, 11);
      if (r == 0)      a = a + 32'($urandom_range(1, 3));
      else if (r == 1) a = base_of(k) + 32'(4 * depth_of(k)) + 32'(4 * $urandom_range(0, 7));
      else if (r == 2) a = base_of(k) - 32'(4 * $urandom_range(1, 4));
      t.addr      = a;
      t.exp_err   = !legal(k, a);
      t.known     = 1'b0;
      t.exp_rdata = 32'h0;
      if (t.sel && !t.exp_err) begin
        wi = word_of(k, a);
        if (t.wr) begin
          mm[k][wi] = t.wdata; mv[k][wi] = 1'b1;
        end else begin
          t.known = mv[k][wi]; t.exp_rdata = mm[k][wi];
        end
      end
      q.push_back(t);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t t;
    tv[0]  = '{0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0};
    tv[1]  = '{0, 1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF};
    tv[2]  = '{0, 1, 1, 32'h0000_0000, 32'hA5A5_0000, 0, 32'h0};
    tv[3]  = '{0, 1, 0, 32'h0000_0400, 32'h0,         1, 32'h0};
    tv[4]  = '{0, 1, 1, 32'h0000_0002, 32'hBAD0_BAD0, 1, 32'h0};
    tv[5]  = '{0, 1, 0, 32'h0000_0000, 32'h0,         0, 32'hA5A5_0000};
    tv[6]  = '{0, 1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF};
    tv[7]  = '{1, 1, 1, 32'h0000_0020, 32'h1234_5678, 0, 32'h0};
    tv[8]  = '{1, 1, 0, 32'h0000_0020, 32'h0,         0, 32'h1234_5678};
    tv[9]  = '{1, 1, 0, 32'h0000_0100, 32'h0,         1, 32'h0};
    tv[10] = '{1, 1, 0, 32'h0000_0020, 32'h0,         0, 32'h1234_5678};
    tv[11] = '{2, 1, 1, 32'h0000_0000, 32'h1,         0, 32'h0};
    tv[12] = '{2, 1, 1, 32'h0000_0004, 32'h2,         0, 32'h0};
    tv[13] = '{2, 1, 1, 32'h0000_0008, 32'h3,         0, 32'h0};
    tv[14] = '{2, 1, 0, 32'h0000_0000, 32'h0,         0, 32'h1};
    tv[15] = '{2, 1, 0, 32'h0000_0004, 32'h0,         0, 32'h2};
    tv[16] = '{2, 1, 0, 32'h0000_0008, 32'h0,         0, 32'h3};
    tv[17] = '{3, 1, 1, 32'h0000_0400, 32'h11,        0, 32'h0};
    tv[18] = '{3, 1, 1, 32'h0000_043C, 32'h22,        0, 32'h0};
    tv[19] = '{3, 1, 1, 32'h0000_0440, 32'h33,        1, 32'h0};
    tv[20] = '{3, 1, 0, 32'h0000_03FC, 32'h0,         1, 32'h0};
    tv[21] = '{3, 1, 0, 32'h0000_0400, 32'h0,         0, 32'h11};
    tv[22] = '{3, 0, 0, 32'h0000_0404, 32'h0,         0, 32'h0};
    tv[23] = '{3, 1, 0, 32'h0000_043C, 32'h0,         0, 32'h22};
    tv[24] = '{3, 1, 0, 32'h0000_0000, 32'h0,         1, 32'h0};

    t_sel = '0; t_addr = '0; t_wr = '0; t_wdata = '0;

    // Reset state, checked while reset is held.
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset hready i%0d", k), {31'b0, o_rdy[k]}, 32'h1);
      chk($sformatf("reset hresp i%0d", k), {31'b0, o_resp[k]}, 32'h0);
      chk($sformatf("reset hrdata i%0d", k), o_rdata[k], 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table, one pipelined burst per instance.
    for (int i = 0; i < NV; i++) begin
      t.sel = tv[i].sel; t.wr = tv[i].wr; t.addr = tv[i].addr; t.wdata = tv[i].wdata;
      t.exp_err = tv[i].exp_err; t.exp_rdata = tv[i].exp_rdata; t.known = 1'b1;
      model_write(tv[i].inst, t);
      q.push_back(t);
      if (i == NV - 1 || tv[i + 1].inst != tv[i].inst) run_q(tv[i].inst);
    end

    // Asynchronous reset in the middle of a read wait cycle.
    t_sel[1] = 1'b1; t_addr[1] = 32'h20; t_wr[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    t_sel[1] = 1'b0;
    chk("pre-reset hready", {31'b0, o_rdy[1]}, 32'h0);
    chk("pre-reset hrdata", o_rdata[1], 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset hready", {31'b0, o_rdy[1]}, 32'h1);
    chk("async reset hresp", {31'b0, o_resp[1]}, 32'h0);
    chk("async reset hrdata", o_rdata[1], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post-reset idle hready", {31'b0, o_rdy[1]}, 32'h1);

    // Reset in the second wait cycle of a write: the word must keep its value.
    t_sel[1] = 1'b1; t_addr[1] = 32'h20; t_wr[1] = 1'b1; t_wdata[1] = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    t_sel[1] = 1'b0;
    chk("abort write wait1 hready", {31'b0, o_rdy[1]}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort write reset hready", {31'b0, o_rdy[1]}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort write idle hready", {31'b0, o_rdy[1]}, 32'h1);
    chk("abort write idle hresp", {31'b0, o_resp[1]}, 32'h0);
    t = '{1, 0, 32'h20, 32'h0, 0, 32'h1234_5678, 1};
    q.push_back(t);
    run_q(1);

    // Randomized pipelined traffic against the memory model.
    for (int k = 0; k < 4; k++) begin
      gen_random(k, 60);
      run_q(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
